rst_seq_sync: RTL and testbench

//  Multi-channel reset synchroniser and release sequencer, the parametrised successor to our single-chain reset sync.

---
 rtl/rst_seq_pkg.sv | 17 +
 rtl/rst_req_sync.sv | 29 ++
 rtl/rst_seq_sync.sv | 135 +++++++++++++
 tb/tb_rst_seq_sync.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the multi-channel reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        GAP,
        DONE
    } state_e;

    // Counter must hold the larger of the two thresholds.
    function automatic int cnt_width(input int stretch_cyc, input int gap_cyc);
        int max_cyc;
        max_cyc = (stretch_cyc > gap_cyc) ? stretch_cyc : gap_cyc;
        return $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/rst_req_sync.sv
// One-bit synchroniser for an async active-low reset request; block reset
// forces the chain to the asserted (0) value.
module rst_req_sync #(
    parameter int SYNC_DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_rstn_i,
    output logic req_s_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic [SYNC_DEPTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], req_rstn_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign req_s_o = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Multi-channel reset synchroniser and ascending release sequencer; a request
// on channel j re-asserts j and all higher channels.
module rst_seq_sync
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_DEPTH  = 2,
    parameter int STRETCH_CYC = 16,
    parameter int GAP_CYC     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] req_rstn_i,
    input  logic              sw_rst_i,
    output logic [NUM_CH-1:0] rstn_o,
    output logic              rst_done_o
);

    localparam int CNT_W = cnt_width(STRETCH_CYC, GAP_CYC);
    localparam int CUR_W = $clog2(NUM_CH + 1);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [CUR_W-1:0] LAST_CH      = CUR_W'(NUM_CH - 1);
    localparam logic [CUR_W-1:0] ALL_CH       = CUR_W'(NUM_CH);

    logic [NUM_CH-1:0] req_s;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sync
            rst_req_sync #(
                .SYNC_DEPTH(SYNC_DEPTH)
            ) u_sync (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .req_rstn_i(req_rstn_i[gi]),
                .req_s_o   (req_s[gi])
            );
        end
    endgenerate

    state_e            state_q, state_d;
    logic [CUR_W-1:0]  cur_q, cur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] rstn_q, rstn_d;
    logic              done_q, done_d;

    logic              req_hit;
    logic [CUR_W-1:0]  req_ch;
    logic [CNT_W-1:0]  thresh;

    // Lowest requesting channel wins; software reset acts as channel 0.
    always_comb begin
        req_hit = 1'b0;
        req_ch  = '0;
        if (sw_rst_i) begin
            req_hit = 1'b1;
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (!req_s[k]) begin
                    req_hit = 1'b1;
                    req_ch  = CUR_W'(k);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        rstn_d  = rstn_q;
        done_d  = done_q;
        thresh  = (state_q == HOLD) ? STRETCH_LAST : GAP_LAST;

        if (req_hit) begin
            // Channels below the requester keep their current level.
            for (int m = 0; m < NUM_CH; m++) begin
                if (CUR_W'(m) >= req_ch) begin
                    rstn_d[m] = 1'b0;
                end
            end
            cur_d   = (req_ch < cur_q) ? req_ch : cur_q;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = HOLD;
        end else begin
            case (state_q)
                HOLD, GAP: begin
                    if (cnt_q == thresh) begin
                        for (int m = 0; m < NUM_CH; m++) begin
                            if (CUR_W'(m) == cur_q) begin
                                rstn_d[m] = 1'b1;
                            end
                        end
                        cnt_d = '0;
                        if (cur_q == LAST_CH) begin
                            state_d = DONE;
                            cur_d   = ALL_CH;
                            done_d  = 1'b1;
                        end else begin
                            cur_d   = cur_q + CUR_W'(1);
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HOLD;
            cur_q   <= '0;
            cnt_q   <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
        end
    end

    assign rstn_o     = rstn_q;
    assign rst_done_o = done_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
// Directed bench for rst_seq_sync: expected output change events are queued
// with their edge number and compared every cycle.
module tb_rst_seq_sync;

    typedef struct {
        int       cyc;
        logic [3:0] rstn;
        logic     done;
    } ev_t;

    ev_t evq[$];

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] req = 4'hF;
    logic       sw = 1'b0;
    logic [3:0] rstn;
    logic       done;

    logic       rst2 = 1'b1;
    logic [0:0] req2 = 1'b1;
    logic       sw2 = 1'b0;
    logic [0:0] rstn2;
    logic       done2;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int base2 = -1;
    logic [3:0] exp_rstn = 4'h0;
    logic       exp_done = 1'b0;
    logic       exp2;

    always #5 clk = ~clk;

    rst_seq_sync dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_rstn_i(req),
        .sw_rst_i  (sw),
        .rstn_o    (rstn),
        .rst_done_o(done)
    );

    rst_seq_sync #(
        .NUM_CH     (1),
        .SYNC_DEPTH (3),
        .STRETCH_CYC(1),
        .GAP_CYC    (4)
    ) dut1 (
        .clk_i     (clk),
        .rst_i     (rst2),
        .req_rstn_i(req2),
        .sw_rst_i  (sw2),
        .rstn_o    (rstn2),
        .rst_done_o(done2)
    );

    task automatic push(input int c, input logic [3:0] r, input logic d);
        ev_t e;
        e.cyc  = c;
        e.rstn = r;
        e.done = d;
        evq.push_back(e);
    endtask

    task automatic tick();
        ev_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (evq.size() > 0 && evq[0].cyc <= cyc) begin
            e = evq.pop_front();
            exp_rstn = e.rstn;
            exp_done = e.done;
        end
        tests++;
        assert (rstn === exp_rstn) else begin
            fails++;
            $error("FAIL rstn_o cyc=%0d got=%b exp=%b", cyc, rstn, exp_rstn);
        end
        tests++;
        assert (done === exp_done) else begin
            fails++;
            $error("FAIL rst_done_o cyc=%0d got=%b exp=%b", cyc, done, exp_done);
        end
        if (base2 >= 0) begin
            exp2 = (cyc >= base2 + 4);
            tests++;
            assert (rstn2[0] === exp2 && done2 === exp2) else begin
                fails++;
                $error("FAIL one_ch cyc=%0d got rstn=%b done=%b exp=%b", cyc, rstn2, done2, exp2);
            end
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic req_low(input int ch, input int len);
        req[ch] = 1'b0;
        repeat (len) tick();
        req[ch] = 1'b1;
    endtask

    task automatic full_seq(input int b);
        push(b + 18, 4'b0001, 1'b0);
        push(b + 22, 4'b0011, 1'b0);
        push(b + 26, 4'b0111, 1'b0);
        push(b + 30, 4'b1111, 1'b1);
    endtask

    initial begin
        int b;
        int c;
        int c1;

        // Power-up reset, then release with all requests high.
        repeat (3) tick();
        rst_i = 1'b0;
        rst2  = 1'b0;
        b     = cyc;
        base2 = cyc;
        full_seq(b);
        run_to(b + 34);
        $display("[TB] step 1 power-up sequence done at cyc %0d", cyc);

        // One-cycle request on channel 2 from DONE.
        c = cyc;
        push(c + 3,  4'b0011, 1'b0);
        push(c + 19, 4'b0111, 1'b0);
        push(c + 23, 4'b1111, 1'b1);
        req_low(2, 1);
        run_to(c + 27);
        $display("[TB] step 2 channel-2 request done at cyc %0d", cyc);

        // Software reset from DONE: replay without sync delay.
        c = cyc;
        push(c + 1,  4'b0000, 1'b0);
        push(c + 17, 4'b0001, 1'b0);
        push(c + 21, 4'b0011, 1'b0);
        sw = 1'b1;
        tick();
        sw = 1'b0;
        run_to(c + 22);
        $display("[TB] step 3 sw reset replay reached cur=2 at cyc %0d", cyc);

        // Channel-1 request lands exactly on the channel-2 release edge.
        c1 = cyc;
        push(c1 + 3,  4'b0001, 1'b0);
        push(c1 + 19, 4'b0011, 1'b0);
        push(c1 + 23, 4'b0111, 1'b0);
        push(c1 + 27, 4'b1111, 1'b1);
        req_low(1, 1);
        run_to(c1 + 31);
        $display("[TB] step 4 channel-1 request in GAP done at cyc %0d", cyc);

        // Channel-3 request held 10 cycles while HOLD with cur=0.
        c = cyc;
        push(c + 1, 4'b0000, 1'b0);
        sw = 1'b1;
        tick();
        sw = 1'b0;
        run_to(c + 3);
        c1 = cyc;
        push(c1 + 28, 4'b0001, 1'b0);
        push(c1 + 32, 4'b0011, 1'b0);
        push(c1 + 36, 4'b0111, 1'b0);
        push(c1 + 40, 4'b1111, 1'b1);
        req_low(3, 10);
        run_to(c1 + 44);
        $display("[TB] step 5 channel-3 held request done at cyc %0d", cyc);

        // Block reset mid-sequence at cycle 25 of a fresh sequence.
        c = cyc;
        push(c + 1, 4'b0000, 1'b0);
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        b = cyc;
        push(b + 18, 4'b0001, 1'b0);
        push(b + 22, 4'b0011, 1'b0);
        run_to(b + 24);
        rst_i = 1'b1;
        push(b + 25, 4'b0000, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;
        b = cyc;
        full_seq(b);
        run_to(b + 34);
        $display("[TB] step 6 mid-sequence reset done at cyc %0d", cyc);

        tests++;
        assert (evq.size() == 0) else begin
            fails++;
            $error("FAIL event_queue leftover=%0d exp=0", evq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
